// File: rtl/tt_uart_tx_pkg.sv
// rtl/tt_uart_tx_pkg.sv - shared types and constants for the tt_uart_tx transmitter
//
// Purpose: FSM state encoding and frame-size constants used by tt_uart_tx.
// Build option: UART_TX_PARITY_EN selects 8E1 frames (11 bits) instead of 8N1 (10 bits).

package tt_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/tt_uart_tx_fifo.sv
// rtl/tt_uart_tx_fifo.sv - small synchronous FIFO buffering bytes for the UART transmitter
//
// Purpose: DEPTH x WIDTH FIFO with registered level and full flags.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (flushes the FIFO)
//   push         write request; ignored while full
//   push_data    data written on push
//   pop          read request; ignored while empty
//   pop_data     head entry (valid while level != 0)
//   level        number of entries held, registered
//   full         level == DEPTH, registered

module tt_uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && (level != '0);
  assign pop_data = mem[rd_ptr];

  // A simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop) begin
      level_nxt = level + LW'(1);
    end else if (!do_push && do_pop) begin
      level_nxt = level - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tt_uart_tx.sv
// rtl/tt_uart_tx.sv - byte-serial UART transmitter with write FIFO
//
// Purpose: accepts bytes on a valid/ready port, buffers them, and shifts them out on txd as
//   8N1 frames (8E1 when UART_TX_PARITY_EN is defined), LSB first, idle high.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high; aborts any frame and flushes the FIFO
//   div          clk cycles per bit minus 1, sampled when a byte is popped
//   wr_valid     wr_data is valid
//   wr_data      byte to transmit
//   wr_ready     FIFO can accept a byte (registered)
//   txd          serial output, registered
//   busy         frame in progress or FIFO not empty
//   fifo_level   bytes held in the FIFO
// Build option: UART_TX_PARITY_EN inserts an even parity bit after the data bits.

module tt_uart_tx
  import tt_uart_tx_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              div,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  state_t               state;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 txd_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       bit_end;
  logic       pop;

  assign fifo_empty = (fifo_level == '0);
  assign bit_end    = (baud_cnt == '0);

  // Pop from IDLE, or at the last cycle of STOP so the next start bit follows with no gap.
  assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

  tt_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full)
  );

  assign wr_ready = !fifo_full;
  assign txd      = txd_q;
  assign busy     = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_q    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (pop) begin
      // Load a new frame; div is latched here so mid-frame changes are ignored.
      state    <= START;
      shift_q  <= fifo_head;
      div_q    <= div;
      baud_cnt <= div;
      bit_idx  <= '0;
      txd_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= even_parity(fifo_head);
`endif
    end else begin
      case (state)
        IDLE: begin
          txd_q <= 1'b1;
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            baud_cnt <= div_q;
            bit_idx  <= '0;
            txd_q    <= shift_q[0];
            shift_q  <= {1'b0, shift_q[DATA_BITS-1:1]};
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= div_q;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              txd_q <= parity_q;
`else
              state <= STOP;
              txd_q <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd_q   <= shift_q[0];
              shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
            end
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        PARITY: begin
`ifdef UART_TX_PARITY_EN
          if (bit_end) begin
            state    <= STOP;
            baud_cnt <= div_q;
            txd_q    <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
`else
          // Unreachable without the parity option.
          state <= IDLE;
          txd_q <= 1'b1;
`endif
        end
        STOP: begin
          // A non-empty FIFO at the end of STOP is handled by the pop branch above.
          if (bit_end) begin
            state <= IDLE;
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          txd_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_uart_tx.sv
// tb/tb_tt_uart_tx.sv - directed self-checking bench for tt_uart_tx

module tb_tt_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int   FL        = 11;
  localparam logic P03_BIT9  = 1'b0;
`else
  localparam int   FL        = 10;
  localparam logic P03_BIT9  = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        txd;
  logic        busy;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_uart_tx #(
    .DIV_W      (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .div        (div),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  // Expected line level for bit position idx of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b expected 1", txd); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b expected 1", wr_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d expected 0", fifo_level); end
    rst = 1'b0;
    @(negedge clk);
    // Start a frame, then assert rst between clock edges.
    div = 16'd3; wr_data = 8'h00; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL async_pre_busy got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL async_pre_txd got %b expected 0", txd); end
    #2 rst = 1'b1;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL async_txd got %b expected 1", txd); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL async_wr_ready got %b expected 1", wr_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b expected 0", busy); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL async_level got %0d expected 0", fifo_level); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    logic [7:0] b;
    logic       exp;
    b = 8'hA5;
    div = 16'd3; wr_data = b; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL single_no_bypass txd got %b expected 1", txd); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level got %0d expected 1", fifo_level); end
    for (int k = 1; k <= FL * 4 + 1; k++) begin
      @(negedge clk);
      exp = (k <= FL * 4) ? frame_bit(b, (k - 1) / 4) : 1'b1;
      checks++; if (txd !== exp) begin errors++; $display("FAIL single_txd k=%0d got %b expected %b", k, txd, exp); end
      if (k == 1) begin
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_popped level got %0d expected 0", fifo_level); end
      end
      if (k == FL * 4) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_last got %b expected 1", busy); end
      end
      if (k == FL * 4 + 1) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b expected 0", busy); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b [6];
    int         sent;
    bit         rdy_before;
    int         zeros;
    int         first_zero;
    int         first_rec;
    logic       exp;
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    sent = 0; zeros = 0; first_zero = -1; first_rec = -1;
    div = 16'd0; wr_data = b[0]; wr_valid = 1'b1;
    rdy_before = wr_ready;
    for (int i = 0; i <= FL * 6 + 1; i++) begin
      @(negedge clk);
      if (wr_valid && rdy_before) sent++;
      if (sent == 6) wr_valid = 1'b0;
      else wr_data = b[sent];
      rdy_before = wr_ready;
      if (!wr_ready) begin
        zeros++;
        if (first_zero < 0) first_zero = i;
      end else if (first_zero >= 0 && first_rec < 0) begin
        first_rec = i;
      end
      if (i == 4) begin
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL b2b_full_level got %0d expected 4", fifo_level); end
      end
      if (i >= 1 && i <= FL * 6) begin
        exp = frame_bit(b[(i - 1) / FL], (i - 1) % FL);
        checks++; if (txd !== exp) begin errors++; $display("FAIL b2b_txd i=%0d got %b expected %b", i, txd, exp); end
      end
      if (i == FL * 6) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_last got %b expected 1", busy); end
      end
      if (i == FL * 6 + 1) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b expected 0", busy); end
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL b2b_idle_txd got %b expected 1", txd); end
      end
    end
    wr_valid = 1'b0;
    checks++; if (sent != 6) begin errors++; $display("FAIL b2b_sent got %0d expected 6", sent); end
    checks++; if (first_zero != 4) begin errors++; $display("FAIL b2b_ready_drop got %0d expected 4", first_zero); end
    checks++; if (first_rec != FL + 1) begin errors++; $display("FAIL b2b_ready_recover got %0d expected %0d", first_rec, FL + 1); end
    checks++; if (zeros != 2 * FL - 4) begin errors++; $display("FAIL b2b_ready_low_cycles got %0d expected %0d", zeros, 2 * FL - 4); end
  endtask

  task automatic test_div_change;
    logic exp;
    div = 16'd2; wr_data = 8'h3C; wr_valid = 1'b1;
    @(negedge clk);
    wr_data = 8'h81;
    for (int k = 1; k <= FL * 11 + 1; k++) begin
      @(negedge clk);
      if (k == 1) wr_valid = 1'b0;
      if (k == 8) div = 16'd7;
      if (k <= FL * 3) exp = frame_bit(8'h3C, (k - 1) / 3);
      else if (k <= FL * 11) exp = frame_bit(8'h81, (k - 1 - FL * 3) / 8);
      else exp = 1'b1;
      checks++; if (txd !== exp) begin errors++; $display("FAIL divchg_txd k=%0d got %b expected %b", k, txd, exp); end
      if (k == FL * 11) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divchg_busy_last got %b expected 1", busy); end
      end
      if (k == FL * 11 + 1) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divchg_busy_end got %b expected 0", busy); end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int bad;
    div = 16'd3; wr_data = 8'h55; wr_valid = 1'b1;
    @(negedge clk);
    wr_data = 8'hAA;
    @(negedge clk);
    wr_data = 8'h0F;
    @(negedge clk);
    wr_valid = 1'b0;
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL rstmid_queued got %0d expected 2", fifo_level); end
    // Now at k=2; data bit 3 of 0x55 (a 0) occupies k=17..20.
    repeat (16) @(negedge clk);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL rstmid_bit3 got %b expected 0", txd); end
    #2 rst = 1'b1;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rstmid_txd got %b expected 1", txd); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rstmid_level got %0d expected 0", fifo_level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b expected 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_parity;
    logic [7:0] b [2];
    logic       bit9 [2];
    logic       exp;
    b = '{8'h07, 8'h03};
    bit9 = '{1'b1, P03_BIT9};
    div = 16'd1;
    for (int n = 0; n < 2; n++) begin
      wr_data = b[n]; wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
      for (int k = 1; k <= FL * 2 + 1; k++) begin
        @(negedge clk);
        exp = (k <= FL * 2) ? frame_bit(b[n], (k - 1) / 2) : 1'b1;
        checks++; if (txd !== exp) begin errors++; $display("FAIL par_txd n=%0d k=%0d got %b expected %b", n, k, txd, exp); end
        if (k == 19) begin
          checks++; if (txd !== bit9[n]) begin errors++; $display("FAIL par_bit9 n=%0d got %b expected %b", n, txd, bit9[n]); end
        end
        if (k == FL * 2) begin
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL par_busy_last n=%0d got %b expected 1", n, busy); end
        end
        if (k == FL * 2 + 1) begin
          checks++; if (busy !== 1'b0) begin errors++; $display("FAIL par_busy_end n=%0d got %b expected 0", n, busy); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    div = 16'd0;
    wr_valid = 1'b0;
    wr_data = 8'h00;
    test_reset;
    test_single;
    test_back_to_back;
    test_div_change;
    test_reset_mid_frame;
    test_parity;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
